// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC thermometer decoder: defaults, fine-code width
// helper and the timestamp word layout.
package tdc_pkg;

  localparam int DEFAULT_NFF = 32;
  localparam int DEFAULT_CW  = 16;

  // Fine code must hold every ones-count from 0 up to and including NFF.
  function automatic int fine_width(input int nff);
    return $clog2(nff + 1);
  endfunction

  localparam int DEFAULT_FW = fine_width(DEFAULT_NFF);

  typedef struct packed {
    logic [DEFAULT_CW-1:0] coarse;
    logic [DEFAULT_FW-1:0] fine;
  } ts_t;

endpackage

// File: rtl/tdc_popcount.sv
// Registered ones-counter for the thermometer snapshot (pipeline stage S2).
// Balanced adder tree over the taps, padded up to a power of two.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int  NFF = DEFAULT_NFF,
  localparam int FW  = fine_width(NFF)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [NFF-1:0] din,
  output logic           out_valid,
  output logic [FW-1:0]  count
);

  localparam int LEAVES = 1 << $clog2(NFF);

  // Heap-ordered tree: node 0 is the root, leaves start at LEAVES-1.
  function automatic logic [FW-1:0] tree_sum(input logic [NFF-1:0] v);
    logic [FW-1:0] node [2*LEAVES-1];
    for (int i = 0; i < LEAVES; i++) begin
      if (i < NFF) node[LEAVES-1+i] = FW'(v[i]);
      else         node[LEAVES-1+i] = '0;
    end
    for (int i = LEAVES - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    return node[0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= in_valid;
      count     <= tree_sum(din);
    end
  end

endmodule

// File: rtl/tdc_therm_decoder.sv
// Converts registered delay-line thermometer snapshots into {coarse, fine}
// timestamps on a valid/ready port. Optional bubble filter: TDC_BUBBLE_FILTER_EN.
module tdc_therm_decoder
  import tdc_pkg::*;
#(
  parameter int  NFF = DEFAULT_NFF,
  parameter int  CW  = DEFAULT_CW,
  localparam int FW  = fine_width(NFF)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NFF-1:0] therm_in,
  output logic           ts_valid,
  input  logic           ts_ready,
  output logic [FW-1:0]  ts_fine,
  output logic [CW-1:0]  ts_coarse,
  output logic           ovf
);

  // Same layout as tdc_pkg::ts_t, sized by this instance's parameters.
  typedef struct packed {
    logic [CW-1:0] coarse;
    logic [FW-1:0] fine;
  } ts_word_t;

  logic [CW-1:0]  coarse;
  logic           prev0;
  logic           hit;
  logic [NFF-1:0] filt;

  logic           s1_v;
  logic [NFF-1:0] s1_therm;
  logic [CW-1:0]  s1_coarse;

  logic           s2_v;
  logic [FW-1:0]  s2_fine;
  logic [CW-1:0]  s2_coarse;

  logic           out_valid;
  ts_word_t       out_q;
  logic           load;
  logic           drop;

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad with a virtual 1 below tap 0 and a virtual 0 above the last tap.
  logic [NFF+1:0] ext;
  assign ext = {1'b0, therm_in, 1'b1};

  always_comb begin
    filt = '0;
    for (int k = 0; k < NFF; k++) begin
      filt[k] = (ext[k] & ext[k+1]) | (ext[k] & ext[k+2]) | (ext[k+1] & ext[k+2]);
    end
  end
`else
  assign filt = therm_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + 1'b1;
  end

  // Edge detect on the raw first tap so a long pulse counts once.
  assign hit = therm_in[0] & ~prev0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev0     <= 1'b0;
      s1_v      <= 1'b0;
      s1_therm  <= '0;
      s1_coarse <= '0;
    end else begin
      prev0 <= therm_in[0];
      s1_v  <= hit;
      if (hit) begin
        s1_therm  <= filt;
        s1_coarse <= coarse;
      end
    end
  end

  tdc_popcount #(
    .NFF(NFF)
  ) u_popcount (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_v),
    .din      (s1_therm),
    .out_valid(s2_v),
    .count    (s2_fine)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2_coarse <= '0;
    else     s2_coarse <= s1_coarse;
  end

  // S1/S2 never stall; a stage-2 result that finds the output occupied is lost.
  assign load = s2_v & (~out_valid | ts_ready);
  assign drop = s2_v & out_valid & ~ts_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        out_valid    <= 1'b1;
        out_q.coarse <= s2_coarse;
        out_q.fine   <= s2_fine;
      end else if (ts_ready) begin
        out_valid <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  assign ts_valid  = out_valid;
  assign ts_fine   = out_q.fine;
  assign ts_coarse = out_q.coarse;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Self-checking bench for tdc_therm_decoder (NFF=32, CW=4) against a
// transaction-level timestamp model; follows TDC_BUBBLE_FILTER_EN like the DUT.
module tb_tdc_therm_decoder;

  localparam int NFF = 32;
  localparam int CW  = 4;
  localparam int FW  = 6;

`ifdef TDC_BUBBLE_FILTER_EN
  localparam int BUBBLE_FINE = 8;
`else
  localparam int BUBBLE_FINE = 7;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NFF-1:0] therm_in;
  logic           ts_ready;
  logic           ts_valid;
  logic [FW-1:0]  ts_fine;
  logic [CW-1:0]  ts_coarse;
  logic           ovf;

  int errors   = 0;
  int checks   = 0;
  int hs_count = 0;

  // Model state: what the output port should show, plus hits still in flight.
  logic          m_valid;
  logic          m_ovf;
  logic          m_prev0;
  logic [FW-1:0] m_fine;
  logic [CW-1:0] m_coarse;
  int            m_cyc;
  int            m_edge;
  int            q_due[$];
  int            q_fine[$];
  int            q_coarse[$];

  always #5 clk = ~clk;

  tdc_therm_decoder #(
    .NFF(NFF),
    .CW (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .therm_in (therm_in),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .ts_fine  (ts_fine),
    .ts_coarse(ts_coarse),
    .ovf      (ovf)
  );

  function automatic logic [NFF-1:0] filt_model(input logic [NFF-1:0] t);
    logic [NFF-1:0] r;
    r = t;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int k = 0; k < NFF; k++) begin
      int below;
      int above;
      below = (k == 0) ? 1 : int'(t[k-1]);
      above = (k == NFF - 1) ? 0 : int'(t[k+1]);
      r[k] = ((below + int'(t[k]) + above) >= 2);
    end
`endif
    return r;
  endfunction

  function automatic logic [NFF-1:0] gen_therm(input int min_len, input bit bubbles);
    int          len;
    logic [63:0] w;
    logic [NFF-1:0] v;
    len = $urandom_range(NFF, min_len);
    w   = (64'd1 << len) - 64'd1;
    v   = w[NFF-1:0];
    if (bubbles && ($urandom_range(3, 0) == 0)) v[$urandom_range(NFF - 1, 0)] ^= 1'b1;
    return v;
  endfunction

  task automatic model_clear();
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_prev0  = 1'b0;
    m_fine   = '0;
    m_coarse = '0;
    m_cyc    = 0;
    m_edge   = 0;
    q_due.delete();
    q_fine.delete();
    q_coarse.delete();
  endtask

  // One rising edge: a hit appears at the output two edges after its snapshot.
  task automatic model_edge(input logic [NFF-1:0] t, input logic r);
    if (q_due.size() > 0 && q_due[0] == m_edge) begin
      if (!m_valid || r) begin
        m_valid  = 1'b1;
        m_fine   = FW'(q_fine[0]);
        m_coarse = CW'(q_coarse[0]);
      end else begin
        m_ovf = 1'b1;
      end
      void'(q_due.pop_front());
      void'(q_fine.pop_front());
      void'(q_coarse.pop_front());
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (t[0] && !m_prev0) begin
      q_due.push_back(m_edge + 2);
      q_fine.push_back($countones(filt_model(t)));
      q_coarse.push_back(m_cyc % (1 << CW));
    end
    m_prev0 = t[0];
    m_cyc++;
    m_edge++;
  endtask

  task automatic applyStimulus(input logic [NFF-1:0] t, input logic r);
    therm_in = t;
    ts_ready = r;
    if (ts_valid && ts_ready) hs_count++;
    @(posedge clk);
    model_edge(t, r);
    #1;
  endtask

  task automatic applyReset();
    rst      = 1'b1;
    therm_in = '0;
    ts_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    therm_in = '0;
    ts_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ts_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", ts_valid); end
    checks++;
    if (ts_fine !== '0) begin errors++; $display("[TB] FAIL reset_fine: got %0d expected 0", ts_fine); end
    checks++;
    if (ts_coarse !== '0) begin errors++; $display("[TB] FAIL reset_coarse: got %0d expected 0", ts_coarse); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
    rst = 1'b0;
    model_clear();
    for (int e = 0; e < 3; e++) begin
      applyStimulus('0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL reset_idle: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
    end
  endtask

  task automatic test_latency();
    applyReset();
    for (int e = 0; e < 12; e++) begin
      applyStimulus((e == 4) ? 32'h0000_00FF : 32'h0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL latency_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
      if (e == 5) begin
        checks++;
        if (ts_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got valid=%0b expected 0", ts_valid); end
      end
      if (e == 6) begin
        checks++;
        if (ts_valid !== 1'b1 || ts_fine !== 6'd8 || ts_coarse !== 4'd4) begin
          errors++;
          $display("[TB] FAIL latency_ts: got v=%0b f=%0d c=%0d expected v=1 f=8 c=4", ts_valid, ts_fine, ts_coarse);
        end
      end
    end
  endtask

  task automatic test_hold();
    hs_count = 0;
    for (int e = 0; e < 14; e++) begin
      applyStimulus((e < 5) ? 32'h0000_00FF : 32'h0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL hold_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
    end
    checks++;
    if (hs_count !== 1) begin errors++; $display("[TB] FAIL hold_count: got %0d timestamps expected 1", hs_count); end
  endtask

  task automatic test_bubble();
    for (int e = 0; e < 6; e++) begin
      applyStimulus((e == 0) ? 32'h0000_00F7 : 32'h0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL bubble_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
      if (e == 2) begin
        checks++;
        if (ts_valid !== 1'b1 || int'(ts_fine) !== BUBBLE_FINE) begin
          errors++;
          $display("[TB] FAIL bubble_fine: got v=%0b f=%0d expected v=1 f=%0d", ts_valid, ts_fine, BUBBLE_FINE);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < 16; e++) begin
      applyStimulus((e == 0) ? 32'h0000_003F : ((e == 4) ? 32'h0000_0FFF : 32'h0), 1'b0);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL bp_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
      if (e == 15) begin
        checks++;
        if (ts_valid !== 1'b1 || ts_fine !== 6'd6 || ovf !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bp_held: got v=%0b f=%0d ovf=%0b expected v=1 f=6 ovf=1", ts_valid, ts_fine, ovf);
        end
      end
    end
    for (int e = 0; e < 3; e++) begin
      applyStimulus('0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL bp_drain: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
    end
    checks++;
    if (ts_valid !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_sticky: got v=%0b ovf=%0b expected v=0 ovf=1", ts_valid, ovf);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus('0, 1'b1);
    applyStimulus(32'h0000_00FF, 1'b1);
    rst = 1'b1;
    #2;
    checks++;
    if ({ts_valid, ovf, ts_fine, ts_coarse} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got v=%0b o=%0b f=%0d c=%0d expected all 0", ts_valid, ovf, ts_fine, ts_coarse);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    for (int e = 0; e < 8; e++) begin
      applyStimulus('0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse} || ts_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_after: got v=%0b o=%0b f=%0d c=%0d expected v=0 o=0 f=0 c=0",
                 ts_valid, ovf, ts_fine, ts_coarse);
      end
    end
  endtask

  task automatic test_wrap();
    applyReset();
    for (int e = 0; e < 23; e++) begin
      applyStimulus((e == 15 || e == 17) ? 32'h0000_0001 : 32'h0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL wrap_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
      if (e == 17) begin
        checks++;
        if (ts_valid !== 1'b1 || ts_coarse !== 4'd15) begin
          errors++;
          $display("[TB] FAIL wrap_15: got v=%0b c=%0d expected v=1 c=15", ts_valid, ts_coarse);
        end
      end
      if (e == 19) begin
        checks++;
        if (ts_valid !== 1'b1 || ts_coarse !== 4'd1) begin
          errors++;
          $display("[TB] FAIL wrap_1: got v=%0b c=%0d expected v=1 c=1", ts_valid, ts_coarse);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    applyReset();
    hs_count = 0;
    for (int e = 0; e < 40; e++) begin
      applyStimulus((e % 2 == 0 && e < 30) ? gen_therm(1, 1'b0) : 32'h0, 1'b1);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL b2b_model: got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
    end
    checks++;
    if (hs_count !== 15 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_rate: got %0d timestamps ovf=%0b expected 15 ovf=0", hs_count, ovf);
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int e = 0; e < 400; e++) begin
      logic r;
      r = (e >= 150 && e < 200) ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0);
      applyStimulus($urandom_range(1, 0) ? gen_therm(1, 1'b1) : 32'h0, r);
      checks++;
      if ({ts_valid, ovf, ts_fine, ts_coarse} !== {m_valid, m_ovf, m_fine, m_coarse}) begin
        errors++;
        $display("[TB] FAIL random_model: cycle %0d got v=%0b o=%0b f=%0d c=%0d expected v=%0b o=%0b f=%0d c=%0d",
                 e, ts_valid, ovf, ts_fine, ts_coarse, m_valid, m_ovf, m_fine, m_coarse);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    therm_in = '0;
    ts_ready = 1'b0;
    model_clear();
    $display("[TB] tdc_therm_decoder bench start");
    test_reset();
    test_latency();
    test_hold();
    test_bubble();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
# tdc_therm_decoder

Consumes the registered thermometer snapshot of the tapped delay line produced by the TDC sampling pipeline and converts each hit into a timestamp. A hit yields a fine code (number of taps reached, ones-count) and a coarse code (free-running cycle counter). The timestamp is delivered on a valid/ready interface to the downstream readout FIFO. The block sits directly after the sampling flip-flop row in the same clock domain.

## Interface
- NFF, 32: delay-line taps / thermometer width; legal range 4..512
- CW, 16: coarse counter width
- FW, $clog2(NFF+1): fine code width (derived, not overridable)
- clk  in  1  sampling clock, same as the sampling pipeline
- rst  in  1  asynchronous, active-high reset
- therm_in  in  NFF  registered thermometer snapshot; bit 0 = first tap
- ts_valid  out  1  timestamp available
- ts_ready  in  1  downstream accepts when ts_valid & ts_ready at a rising edge
- ts_fine  out  FW  ones-count of the (filtered) snapshot, 0..NFF
- ts_coarse  out  CW  coarse counter value at the cycle the hit was sampled
- ovf  out  1  sticky: at least one hit dropped since reset

## Operation
- Coarse counter: increments every clk, wraps 2^CW-1 -> 0; first cycle after reset release holds 0.
- Hit detection: hit = therm_in[0] & ~prev0, where prev0 is therm_in[0] registered last cycle. Snapshots with therm_in[0]=1 on consecutive cycles produce one hit only.
- Stage 1 (S1): on hit, register filtered snapshot, coarse value, s1_v=1; else s1_v=0.
- Stage 2 (S2): register popcount(S1 snapshot) into FW bits, s2_v, coarse pass-through. All-ones -> NFF, no saturation issue since FW covers NFF.
- Stage 3 (output register): loads when s2_v and (output empty or ts_ready this cycle). Holds value stable while ts_valid & ~ts_ready.
- Drop: s2_v while output full and ~ts_ready -> S2 entry discarded, ovf set; ovf cleared only by rst.
- Pipeline S1/S2 never stalls; only the output register applies backpressure.
- Reset values: ts_valid=0, ts_fine=0, ts_coarse=0, ovf=0, prev0=0, coarse=0, s1_v=s2_v=0.
- Reset mid-operation: all in-flight hits discarded; no ts_valid in the cycle following release.

## Timing
- Snapshot captured at edge n -> ts_valid high after edge n+2 (latency 3 edges, 2 cycles of pipeline) if output register free.
- Maximum hit rate 1 per 2 cycles (rising-edge detection); sustained with ts_ready tied high, no drops.
- Accept at edge m with a new S2 entry at m -> ts_valid stays high, new value after m (back-to-back).
- ts_coarse reports the count at the snapshot edge, not the output edge.

## Configuration
- TDC_BUBBLE_FILTER_EN defined: before S1, each bit k replaced by majority(t[k-1], t[k], t[k+1]) with t[-1]=1, t[NFF]=0; removes single-bit bubbles; no extra latency. hit detection still uses raw therm_in[0].
- Undefined: snapshot passed unfiltered; bubbles count toward ts_fine as-is.

## Structure
- Shared package tdc_pkg: fine-width function (clog2 of NFF+1), default CW, timestamp struct {coarse, fine}.
- One sub-module: tdc_popcount (parameterised NFF, registered output, adder-tree) used by S2.
- Filter, edge detect, coarse counter, output register stay in the top.

## Test plan
- NFF=32: therm_in=0 for 4 cycles, then 0x0000_00FF at edge n, ts_ready=1 -> ts_valid at n+2, ts_fine=8, ts_coarse = counter at n.
- Same snapshot 0x0000_00FF held 5 cycles -> exactly one timestamp.
- Filter enabled: 0x0000_00F7 (bubble at bit 3) -> ts_fine=8; filter disabled -> ts_fine=7.
- ts_ready=0, two hits 4 cycles apart -> first held stable, second dropped, ovf=1; after ts_ready=1 first accepted, ovf remains 1.
- Coarse wrap with CW=4: hit sampled at counter 15 -> ts_coarse=15; next hit 2 cycles later -> ts_coarse=1.
- rst asserted one cycle after hit snapshot -> ts_valid never asserts, all outputs 0, ovf=0.
